uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 8N1-style frames (DATA_BITS data bits, LSB first) sampled at mid-bit,
// with a ready/valid output holding register and frame-error / overrun pulses.
module uart_receiver #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_COUNT = 868
) (
   input  logic                 CLK100MHZ,
   input  logic                 reset_n,
   input  logic                 RXD,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CNT_W = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_COUNT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_COUNT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic                 sync_meta_q;
   logic                 rxs_q;
   state_t               state_q,     state_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic [IDX_W-1:0]     idx_q,       idx_d;
   logic [DATA_BITS-1:0] shift_q,     shift_d;
   logic                 stop_ok_q,   stop_ok_d;
   logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
   logic                 rx_valid_q,  rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q,   overrun_d;

   // Frame sequencing: every sample point and every state change clears the counter.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      stop_ok_d   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rxs_q) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rxs_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs_q;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d       = '0;
               state_d     = IDLE;
               stop_ok_d   = rxs_q;
               frame_err_d = !rxs_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // A completed good frame always lands; overrun only if the old byte was not taken this cycle.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (stop_ok_q) begin
         rx_data_d  = shift_q;
         rx_valid_d = 1'b1;
         overrun_d  = rx_valid_q && !rx_ready;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta_q <= 1'b1;
         rxs_q       <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         stop_ok_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_meta_q <= RXD;
         rxs_q       <= sync_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         stop_ok_q   <= stop_ok_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule
